// File: rtl/carry_look_ahead_adder_core.sv
// -----------------------------------------------------------------------------
// carry_look_ahead_adder_core
//
// Registered two-level carry-lookahead adder.
//   * 4-bit lookahead blocks form their internal carries as flat
//     sum-of-products of g/p and the block carry-in. Carries never ripple
//     inside a block.
//   * A second-level lookahead unit builds every block carry-in from the
//     group generate/propagate terms (GG/GP) and carry_in.
//   * Sum, carry-out and the optional overflow flag are captured in output
//     registers on every rising clk edge. There is no handshake, and one
//     result is produced per cycle.
//
// Parameters
//   WIDTH      operand/sum width in bits. Must be a positive multiple of 4.
//
// Ports
//   clk        clock, rising-edge active
//   rst        asynchronous active-high reset, clears all outputs
//   a, b       addends
//   carry_in   carry into bit 0
//   S          registered sum, a + b + carry_in modulo 2^WIDTH
//   carry_out  registered carry out of bit WIDTH-1
//   overflow   registered signed-overflow flag. This port exists only when
//              the macro CLA_OVERFLOW_EN is defined.
//
// Optional feature macro: CLA_OVERFLOW_EN
// -----------------------------------------------------------------------------
module carry_look_ahead_adder_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] S,
`ifdef CLA_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             carry_out
);

    localparam int NB = WIDTH / 4;  // number of 4-bit lookahead blocks

    logic [WIDTH-1:0] w_g;    // bit generate
    logic [WIDTH-1:0] w_p;    // bit propagate
    logic [WIDTH-1:0] w_c;    // carry into each bit
    logic [WIDTH-1:0] w_s;    // combinational sum
    logic [NB-1:0]    w_gg;   // group generate per block
    logic [NB-1:0]    w_gp;   // group propagate per block
    logic [NB:0]      w_bc;   // block carry-ins; w_bc[NB] is the carry out

    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Second-level lookahead. Each block carry is the OR of every way a carry
    // can arrive: carry_in propagated through all lower blocks, or some lower
    // block generating and all blocks above it propagating. Everything is
    // written out as flat products, so nothing ripples block-to-block.
    function automatic logic [NB:0] f_block_carries(
        input logic [NB-1:0] gg,
        input logic [NB-1:0] gp,
        input logic          cin
    );
        logic [NB:0] c;
        logic        term;
        c    = '0;
        term = 1'b0;
        c[0] = cin;
        for (int k = 1; k <= NB; k++) begin
            term = cin;
            for (int m = 0; m < k; m++) begin
                term = term & gp[m];
            end
            c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = gg[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & gp[m];
                end
                c[k] = c[k] | term;
            end
        end
        return c;
    endfunction

    assign w_bc = f_block_carries(w_gg, w_gp, carry_in);

    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic [3:0] w_bg;
        logic [3:0] w_bp;
        logic       w_ci;

        assign w_bg = w_g[4*k +: 4];
        assign w_bp = w_p[4*k +: 4];
        assign w_ci = w_bc[k];

        // Intra-block carries, each a two-level SOP of g/p and the block carry-in.
        assign w_c[4*k]     = w_ci;
        assign w_c[4*k + 1] = w_bg[0]
                            | (w_bp[0] & w_ci);
        assign w_c[4*k + 2] = w_bg[1]
                            | (w_bp[1] & w_bg[0])
                            | (w_bp[1] & w_bp[0] & w_ci);
        assign w_c[4*k + 3] = w_bg[2]
                            | (w_bp[2] & w_bg[1])
                            | (w_bp[2] & w_bp[1] & w_bg[0])
                            | (w_bp[2] & w_bp[1] & w_bp[0] & w_ci);

        assign w_gg[k] = w_bg[3]
                       | (w_bp[3] & w_bg[2])
                       | (w_bp[3] & w_bp[2] & w_bg[1])
                       | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);
        assign w_gp[k] = &w_bp;
    end

    assign w_s = w_p ^ w_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_cout <= w_bc[NB];
        end
    end

    assign S         = r_s;
    assign carry_out = r_cout;

`ifdef CLA_OVERFLOW_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow occurs when both operands have the same sign and the
    // sum's sign differs from it. A carry_in cannot push mixed-sign
    // operands out of range.
    assign w_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (w_s[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_carry_look_ahead_adder_core.sv
// -----------------------------------------------------------------------------
// tb_carry_look_ahead_adder_core
//
// Self-checking bench for carry_look_ahead_adder_core (WIDTH = 8).
// The driver pushes {overflow, carry_out, S} predicted by an arithmetic
// reference model into exp_q for each vector it applies. The monitor pops one
// entry after every rising edge where an entry is pending and compares it
// against the DUT outputs. Reset and output-hold behaviour are checked
// directly.
// -----------------------------------------------------------------------------
module tb_carry_look_ahead_adder_core;

    localparam int WIDTH = 8;
    localparam int EW    = WIDTH + 2;   // {overflow, carry_out, S}
    localparam int N_RANDOM = 10000;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [WIDTH-1:0] S;
    logic             carry_out;
    logic             overflow;

    int checks;
    int errors;

    logic [EW-1:0] exp_q[$];

    carry_look_ahead_adder_core #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .S         (S),
`ifdef CLA_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .carry_out (carry_out)
    );

`ifndef CLA_OVERFLOW_EN
    assign overflow = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Plain integer arithmetic. The unsigned sum gives {carry_out, S}. Signed
    // overflow means the true signed result falls outside the WIDTH-bit
    // signed range.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] va,
                                            input logic [WIDTH-1:0] vb,
                                            input logic             vci);
        longint ua, ub, us;
        longint sa, sb, sr;
        logic   ov;
        logic [WIDTH:0] sum;
        ua  = longint'(va);
        ub  = longint'(vb);
        us  = ua + ub + longint'(vci);
        sum = us[WIDTH:0];
        sa  = (va[WIDTH-1]) ? ua - (longint'(1) << WIDTH) : ua;
        sb  = (vb[WIDTH-1]) ? ub - (longint'(1) << WIDTH) : ub;
        sr  = sa + sb + longint'(vci);
        ov  = (sr > (longint'(1) << (WIDTH - 1)) - 1) || (sr < -(longint'(1) << (WIDTH - 1)));
        return {ov, sum};
    endfunction

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        logic [EW-1:0] mask;
`ifdef CLA_OVERFLOW_EN
        mask = '1;
`else
        mask = {1'b0, {(EW-1){1'b1}}};
`endif
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s: got ovf=%b cout=%b S=%b, expected ovf=%b cout=%b S=%b",
                     name, act[EW-1], act[WIDTH], act[WIDTH-1:0],
                     exp[EW-1] & mask[EW-1], exp[WIDTH], exp[WIDTH-1:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vci);
        @(negedge clk);
        a        = va;
        b        = vb;
        carry_in = vci;
        exp_q.push_back(model(va, vb, vci));
    endtask

    // Apply a vector, then scramble the inputs mid-cycle and confirm the
    // registered outputs do not move.
    task automatic apply_and_check_hold(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vci);
        apply(va, vb, vci);
        @(posedge clk);
        #3;
        a        = ~va;
        b        = ~vb;
        carry_in = ~vci;
        #1;
        check("hold", {overflow, carry_out, S}, model(va, vb, vci));
    endtask

    // ---------------- monitor ----------------
    always begin
        @(posedge clk);
        #1;
        if (!rst && exp_q.size() > 0) begin
            check("result", {overflow, carry_out, S}, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;

        // Reset is asynchronous: outputs must clear with no clock edge.
        #1;
        rst = 1'b1;
        #1;
        check("reset_async", {overflow, carry_out, S}, '0);
        a        = 8'hFF;
        b        = 8'hFF;
        carry_in = 1'b1;
        @(posedge clk);
        #2;
        check("reset_hold_edge", {overflow, carry_out, S}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        apply(8'b10100110, 8'b10100110, 1'b0);
        apply(8'b10101010, 8'b01010101, 1'b1);
        apply(8'b10101010, 8'b01010101, 1'b0);
        apply(8'b10110111, 8'b11111111, 1'b0);
        apply(8'b10101010, 8'b10101111, 1'b1);
        apply(8'b11111111, 8'b00000000, 1'b1);
        apply(8'b00000000, 8'b00000000, 1'b0);
        apply(8'b01111111, 8'b00000000, 1'b1);
        apply(8'b10000000, 8'b10000000, 1'b0);
        apply(8'b11111111, 8'b11111111, 1'b1);
        apply_and_check_hold(8'b01100101, 8'b00011011, 1'b1);

        // A reset asserted mid-cycle discards the result already held in
        // the output registers and the operands waiting to be sampled.
        apply(8'b11110000, 8'b00110011, 1'b1);
        @(negedge clk);
        a        = 8'b01010101;
        b        = 8'b01110111;
        carry_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_cycle", {overflow, carry_out, S}, '0);
        @(posedge clk);
        #2;
        check("reset_held", {overflow, carry_out, S}, '0);
        @(negedge clk);
        rst      = 1'b0;
        a        = 8'b00000001;
        b        = 8'b00000001;
        carry_in = 1'b0;
        exp_q.push_back(model(8'b00000001, 8'b00000001, 1'b0));

        // Randomized vectors
        for (int i = 0; i < N_RANDOM; i++) begin
            apply(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
